// File: rtl/led_matrix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : led_matrix_pkg                                               |
// | Description : Shared constants, FSM encoding and width helpers for the     |
// |               LED matrix row fetch path.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package led_matrix_pkg;

    localparam int c_DEF_ADDRESS_WIDTH   = 25;
    localparam int c_DEF_DATA_WIDTH      = 16;
    localparam int c_DEF_COLS            = 64;
    localparam int c_DEF_ROWS            = 32;
    localparam int c_DEF_FRAME_BASE0     = 0;
    localparam int c_DEF_FRAME_BASE1     = 2048;
    localparam int c_DEF_MAX_OUTSTANDING = 4;

    localparam int c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_ISSUE = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DONE  = 2'd3;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_pingpong.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : line_buffer_pingpong                                         |
// | Description : Two-bank COLS x DATA_WIDTH line RAM, one write port and one  |
// |               registered read port.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module line_buffer_pingpong
    import led_matrix_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int COLS       = c_DEF_COLS
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic                        wr_bank,
    input  logic [idx_width(COLS)-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_bank,
    input  logic [idx_width(COLS)-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2][COLS];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // No reset on the array or read register so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_bank][wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[rd_bank][rd_addr];
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/matrix_row_fetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matrix_row_fetcher                                           |
// | Description : Fetches one pixel row from memory through an arbiter port    |
// |               into a ping-pong line buffer for the display side.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module matrix_row_fetcher
    import led_matrix_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = c_DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH      = c_DEF_DATA_WIDTH,
    parameter int COLS            = c_DEF_COLS,
    parameter int ROWS            = c_DEF_ROWS,
    parameter int FRAME_BASE0     = c_DEF_FRAME_BASE0,
    parameter int FRAME_BASE1     = c_DEF_FRAME_BASE1,
    parameter int MAX_OUTSTANDING = c_DEF_MAX_OUTSTANDING
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start_row,
    input  logic [idx_width(ROWS)-1:0]  row_index,
    input  logic                        frame_sel,
    output logic [ADDRESS_WIDTH-1:0]    req_address,
    output logic                        req_wr,
    output logic                        req_valid,
    input  logic                        req_fifo_full,
    input  logic [DATA_WIDTH-1:0]       rsp_data,
    input  logic                        rsp_valid,
    input  logic [idx_width(COLS)-1:0]  line_rd_addr,
    output logic [DATA_WIDTH-1:0]       line_rd_data,
    output logic                        busy,
    output logic                        done,
    output logic                        line_bank,
    output logic                        rsp_error
);

    localparam int c_ROW_W = idx_width(ROWS);
    localparam int c_COL_W = idx_width(COLS);
    localparam int c_CNT_W = cnt_width(COLS);
    localparam int c_OUT_W = cnt_width(MAX_OUTSTANDING);

    localparam logic [c_CNT_W-1:0]       c_COLS_CNT  = c_CNT_W'(COLS);
    localparam logic [c_CNT_W-1:0]       c_LAST_CNT  = c_CNT_W'(COLS - 1);
    localparam logic [c_OUT_W-1:0]       c_MAX_OUT   = c_OUT_W'(MAX_OUTSTANDING);
    localparam logic [ADDRESS_WIDTH-1:0] c_BASE0     = ADDRESS_WIDTH'(FRAME_BASE0);
    localparam logic [ADDRESS_WIDTH-1:0] c_BASE1     = ADDRESS_WIDTH'(FRAME_BASE1);
    localparam logic [ADDRESS_WIDTH-1:0] c_COLS_ADDR = ADDRESS_WIDTH'(COLS);

    logic [c_STATE_W-1:0]     r_state;
    logic [c_STATE_W-1:0]     w_state_next;
    logic [c_ROW_W-1:0]       r_row;
    logic                     r_frame;
    logic [c_CNT_W-1:0]       r_issued;
    logic [c_CNT_W-1:0]       r_resp_cnt;
    logic [c_OUT_W-1:0]       r_outstanding;
    logic                     r_line_bank;
    logic                     r_rsp_error;

    logic                     w_start;
    logic                     w_issue;
    logic                     w_in_row;
    logic                     w_rsp_accept;
    logic                     w_rsp_stray;
    logic                     w_last_issue;
    logic                     w_last_rsp;
    logic [ADDRESS_WIDTH-1:0] w_row_addr;

    assign w_start      = (r_state == c_ST_IDLE) && start_row;
    assign w_issue      = (r_state == c_ST_ISSUE) && !req_fifo_full &&
                          (r_outstanding < c_MAX_OUT) && (r_issued < c_COLS_CNT);
    // A response only belongs to the row when something is actually in flight.
    assign w_in_row     = ((r_state == c_ST_ISSUE) || (r_state == c_ST_DRAIN)) &&
                          (r_outstanding != '0);
    assign w_rsp_accept = rsp_valid && w_in_row;
    assign w_rsp_stray  = rsp_valid && !w_in_row;
    assign w_last_issue = w_issue && (r_issued == c_LAST_CNT);
    assign w_last_rsp   = w_rsp_accept && (r_resp_cnt == c_LAST_CNT);
    assign w_row_addr   = (r_frame ? c_BASE1 : c_BASE0) +
                          ADDRESS_WIDTH'(r_row) * c_COLS_ADDR;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (start_row)    w_state_next = c_ST_ISSUE;
            c_ST_ISSUE: if (w_last_issue) w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: if (w_last_rsp || (r_resp_cnt == c_COLS_CNT))
                                          w_state_next = c_ST_DONE;
            c_ST_DONE:                    w_state_next = c_ST_IDLE;
            default:                      w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        req_valid   = w_issue;
        req_wr      = 1'b0;
        req_address = '0;
        if (w_issue) begin
            req_address = w_row_addr + ADDRESS_WIDTH'(r_issued);
        end
        busy      = (r_state != c_ST_IDLE);
        done      = (r_state == c_ST_DONE);
        line_bank = r_line_bank;
        rsp_error = r_rsp_error;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row         <= '0;
            r_frame       <= 1'b0;
            r_issued      <= '0;
            r_resp_cnt    <= '0;
            r_outstanding <= '0;
            r_line_bank   <= 1'b0;
            r_rsp_error   <= 1'b0;
        end else begin
            if (w_start) begin
                r_row      <= row_index;
                r_frame    <= frame_sel;
                r_issued   <= '0;
                r_resp_cnt <= '0;
            end else begin
                if (w_issue) begin
                    r_issued <= r_issued + 1'b1;
                end
                if (w_rsp_accept) begin
                    r_resp_cnt <= r_resp_cnt + 1'b1;
                end
            end

            case ({w_issue, w_rsp_accept})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase

            // Swap banks as the row completes so the freshly filled one goes live.
            if (r_state == c_ST_DONE) begin
                r_line_bank <= ~r_line_bank;
            end
            if (w_rsp_stray) begin
                r_rsp_error <= 1'b1;
            end
        end
    end

    line_buffer_pingpong #(
        .DATA_WIDTH (DATA_WIDTH),
        .COLS       (COLS)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (w_rsp_accept),
        .wr_bank (~r_line_bank),
        .wr_addr (r_resp_cnt[c_COL_W-1:0]),
        .wr_data (rsp_data),
        .rd_bank (r_line_bank),
        .rd_addr (line_rd_addr),
        .rd_data (line_rd_data)
    );

endmodule
`default_nettype wire

// File: doc/matrix_row_fetcher.md
MATRIX_ROW_FETCHER -- requirements
Module: matrix_row_fetcher

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 25, memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, pixel word width.
REQ-003 SHALL have parameter COLS, default 64, pixel words fetched per row.
REQ-004 SHALL have parameter ROWS, default 32, rows per frame.
REQ-005 SHALL have parameter FRAME_BASE0 and FRAME_BASE1, defaults 0 and 2048, frame start addresses.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 4, maximum reads in flight.
REQ-007 SHALL have port clk, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-009 SHALL have port start_row, input, 1, one-cycle pulse requesting a row fetch.
REQ-010 SHALL have port row_index, input, clog2(ROWS), row to fetch; sampled with start_row.
REQ-011 SHALL have port frame_sel, input, 1, selects FRAME_BASE0 (0) or FRAME_BASE1 (1); sampled with start_row.
REQ-012 SHALL have ports req_address (ADDRESS_WIDTH), req_wr (1), and req_valid (1) as outputs; these are the read request to one arbiter peripheral port.
REQ-013 SHALL have port req_fifo_full, input, 1, peripheral FIFO full flag from the arbiter.
REQ-014 SHALL have ports rsp_data (input, DATA_WIDTH) and rsp_valid (input, 1), the read return and its ready strobe.
REQ-015 SHALL have ports line_rd_addr (input, clog2(COLS)) and line_rd_data (output, DATA_WIDTH), the display-side line buffer read.
REQ-016 SHALL have outputs busy (1), done (1), line_bank (1), and rsp_error (1).

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-018 SHALL go from IDLE to ISSUE on start_row, latching row_index, frame_sel, and clearing the issue and response counters.
REQ-019 SHALL assert req_valid in ISSUE only when req_fifo_full=0, outstanding<MAX_OUTSTANDING, and issued<COLS; req_wr SHALL always be 0.
REQ-020 SHALL drive req_address = base + row*COLS + issued, with base set by frame_sel; arithmetic is ADDRESS_WIDTH wide and truncates on overflow.
REQ-021 SHALL increment outstanding on issue and decrement it on rsp_valid; when both happen in one cycle, outstanding SHALL stay unchanged.
REQ-022 SHALL go from ISSUE to DRAIN in the cycle after the COLS-th request is issued.
REQ-023 SHALL go from DRAIN to DONE when the COLS-th response is written.
REQ-024 SHALL pulse done high for exactly one cycle in DONE, then return to IDLE.
REQ-025 SHALL write each rsp_valid word to the inactive bank at its response count; responses arrive in issue order.
REQ-026 SHALL toggle line_bank in the DONE cycle so the newly filled bank becomes the active one.
REQ-027 SHALL return line_rd_data from the active bank one cycle after line_rd_addr (registered read).
REQ-028 SHALL ignore start_row while busy, which is high in ISSUE, DRAIN, and DONE.
REQ-029 SHALL set rsp_error sticky on rsp_valid in IDLE, or on rsp_valid with outstanding=0; the stray word SHALL be discarded.
REQ-030 SHALL clear rsp_error only on reset.
REQ-031 SHALL keep req_valid low while req_fifo_full=1 and resume without losing or duplicating any column.

Reset
REQ-032 SHALL, on reset_n low, immediately force IDLE, req_valid=0, req_wr=0, req_address=0, busy=0, done=0, line_bank=0, rsp_error=0, and all counters=0.
REQ-033 SHALL abandon a mid-row reset with no done pulse; line buffer contents are undefined after reset.

Structure
REQ-034 SHALL place the FSM state encoding and the address/row/column width constants in the shared package led_matrix_pkg.
REQ-035 SHALL contain one sub-module, line_buffer_pingpong: a two-bank COLS x DATA_WIDTH RAM with one write port and one registered read port.

Verification
REQ-036 SHALL verify with COLS=8 and ROWS=4 that start_row with row=2, frame_sel=1 gives 8 req_valid at addresses 2064..2071, then done, with line_bank going from 0 to 1.
REQ-037 SHALL verify that holding req_fifo_full=1 for 5 cycles mid-row gives no req_valid during the hold and still exactly 8 unique addresses in total.
REQ-038 SHALL verify that a 6-cycle response latency with MAX_OUTSTANDING=4 never has more than 4 requests in flight, and that line buffer words 0..7 match memory.
REQ-039 SHALL verify that rsp_valid pulsed in IDLE sets rsp_error=1, which stays 1 through a following good row.
REQ-040 SHALL verify that reset_n asserted after the 3rd response gives immediate IDLE with no done pulse, and that a new start_row then completes normally.
REQ-041 SHALL verify that start_row pulsed during DRAIN is ignored, giving one done pulse and an unchanged latched row.
